// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: serves 256-bit cache line requests as BEATS x 64-bit DRAM bursts (optional ADAPTOR_WATCHDOG_EN stall watchdog).
// Latency: request sampled -> burst next cycle -> line_resp one cycle after the last beat (5 cycles minimum).
// Backpressure: burst_resp=0 stalls the current beat; the cache holds its request until the one-cycle line_resp.
module cacheline_adaptor #(
  parameter int BEATS    = 4,
  parameter int WD_LIMIT = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         line_address,
  input  logic                line_read,
  input  logic                line_write,
  input  logic [64*BEATS-1:0] line_wdata,
  output logic [64*BEATS-1:0] line_rdata,
  output logic                line_resp,
  output logic [31:0]         burst_address,
  output logic                burst_read,
  output logic                burst_write,
  output logic [63:0]         burst_wdata,
  input  logic [63:0]         burst_rdata,
  input  logic                burst_resp,
  output logic                wd_error
);
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [64*BEATS-1:0] wline_q, wline_d;
  logic [64*BEATS-1:0] rline_q, rline_d;
  logic                timeout;
  logic [4:0]          unused_addr_lsb;

  assign unused_addr_lsb = line_address[4:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    case (state_q)
      IDLE: begin
        // Read has priority; a held write is picked up after the read's DONE.
        if (line_read) begin
          addr_d  = {line_address[31:5], 5'b0};
          state_d = RD;
        end else if (line_write) begin
          addr_d  = {line_address[31:5], 5'b0};
          wline_d = line_wdata;
          state_d = WR;
        end
      end
      RD: begin
        if (burst_resp) begin
          rline_d[64*cnt_q +: 64] = burst_rdata;
          cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      WR: begin
        if (burst_resp) begin
          cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d = DONE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  assign line_rdata    = rline_q;
  assign line_resp     = (state_q == DONE);
  assign burst_address = addr_q;
  assign burst_read    = (state_q == RD);
  assign burst_write   = (state_q == WR);
  assign burst_wdata   = (state_q == WR) ? wline_q[64*cnt_q +: 64] : 64'd0;

`ifdef ADAPTOR_WATCHDOG_EN
  localparam int WW = $clog2(WD_LIMIT + 1);

  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
  logic          wd_err_q;
  logic          busy;

  assign busy    = (state_q == RD) || (state_q == WR);
  assign timeout = busy && (wd_cnt_q == WW'(WD_LIMIT));

  // Counter idles at zero, so entry into RD/WR always starts a fresh window.
  always_comb begin
    wd_cnt_d = '0;
    if (busy && !burst_resp && !timeout) wd_cnt_d = wd_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_q | timeout;
    end
  end

  assign wd_error = wd_err_q;
`else
  logic [31:0] unused_wd_limit;

  assign unused_wd_limit = WD_LIMIT;
  assign timeout         = 1'b0;
  assign wd_error        = 1'b0;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reset, read/write bursts, priority, mid-burst reset, stray strobes, watchdog.
module tb_cacheline_adaptor;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  line_address;
  logic         line_read;
  logic         line_write;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  burst_address;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;
  logic         wd_error;

  int n_checks = 0;
  int n_fail   = 0;

  cacheline_adaptor #(.BEATS(4), .WD_LIMIT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .line_address(line_address), .line_read(line_read), .line_write(line_write),
    .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
    .burst_address(burst_address), .burst_read(burst_read), .burst_write(burst_write),
    .burst_wdata(burst_wdata), .burst_rdata(burst_rdata), .burst_resp(burst_resp),
    .wd_error(wd_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: request, then four consecutive beats; returns inside the line_resp cycle.
  task automatic drive_read(input logic [31:0] a, input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3);
    line_address = a;
    line_read    = 1'b1;
    tick();
    burst_resp = 1'b1;
    burst_rdata = b0; tick();
    burst_rdata = b1; tick();
    burst_rdata = b2; tick();
    burst_rdata = b3; tick();
    burst_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    line_address = '0; line_read = 1'b0; line_write = 1'b0; line_wdata = '0;
    burst_rdata = '0; burst_resp = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({line_resp, burst_read, burst_write, wd_error} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b exp 0000", {line_resp, burst_read, burst_write, wd_error}); end
    n_checks++; if (burst_address !== 32'd0) begin
      n_fail++; $display("FAIL reset_addr: got %h exp 0", burst_address); end
    n_checks++; if (burst_wdata !== 64'd0) begin
      n_fail++; $display("FAIL reset_wdata: got %h exp 0", burst_wdata); end
    n_checks++; if (line_rdata !== 256'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h exp 0", line_rdata); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_b2b();
    logic [255:0] exp_line;
    logic [63:0]  beats [4];
    exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    line_address = 32'h0000_1234;
    line_read    = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = beats[i];
      @(negedge clk);
      n_checks++; if ({burst_read, line_resp} !== 2'b10) begin
        n_fail++; $display("FAIL rd_beat%0d_ctrl: got read/resp %b exp 10", i, {burst_read, line_resp}); end
      n_checks++; if (burst_address !== 32'h0000_1220) begin
        n_fail++; $display("FAIL rd_beat%0d_addr: got %h exp 00001220", i, burst_address); end
      tick();
    end
    burst_resp = 1'b0;
    @(negedge clk);
    n_checks++; if ({line_resp, burst_read} !== 2'b10) begin
      n_fail++; $display("FAIL rd_resp_cycle5: got resp/read %b exp 10", {line_resp, burst_read}); end
    n_checks++; if (line_rdata !== exp_line) begin
      n_fail++; $display("FAIL rd_line: got %h exp %h", line_rdata, exp_line); end
    tick();
    line_read = 1'b0;
    @(negedge clk);
    n_checks++; if (line_resp !== 1'b0) begin
      n_fail++; $display("FAIL rd_resp_single: got %b exp 0", line_resp); end
    n_checks++; if (line_rdata !== exp_line) begin
      n_fail++; $display("FAIL rd_line_stable: got %h exp %h", line_rdata, exp_line); end
    tick();
  endtask

  task automatic test_write_stall();
    logic [63:0] wexp [4];
    wexp = '{64'hA, 64'hB, 64'hC, 64'hD};
    line_address = 32'h8000_0117;
    line_wdata   = {64'hD, 64'hC, 64'hB, 64'hA};
    line_write   = 1'b1;
    tick();
    for (int j = 0; j < 8; j++) begin
      burst_resp = (j % 2 == 1);
      @(negedge clk);
      n_checks++; if ({burst_write, line_resp} !== 2'b10) begin
        n_fail++; $display("FAIL wr_cyc%0d_ctrl: got write/resp %b exp 10", j, {burst_write, line_resp}); end
      n_checks++; if (burst_wdata !== wexp[j/2]) begin
        n_fail++; $display("FAIL wr_cyc%0d_data: got %h exp %h", j, burst_wdata, wexp[j/2]); end
      tick();
    end
    burst_resp = 1'b0;
    @(negedge clk);
    n_checks++; if ({line_resp, burst_write} !== 2'b10) begin
      n_fail++; $display("FAIL wr_resp: got resp/write %b exp 10", {line_resp, burst_write}); end
    n_checks++; if (burst_address !== 32'h8000_0100) begin
      n_fail++; $display("FAIL wr_addr: got %h exp 80000100", burst_address); end
    tick();
    line_write = 1'b0;
    @(negedge clk);
    n_checks++; if (line_resp !== 1'b0) begin
      n_fail++; $display("FAIL wr_resp_single: got %b exp 0", line_resp); end
    tick();
  endtask

  task automatic test_simultaneous();
    logic [63:0] wexp [4];
    wexp = '{64'h0101, 64'h0202, 64'h0303, 64'h0404};
    line_address = 32'h4000_0040;
    line_wdata   = {64'h0404, 64'h0303, 64'h0202, 64'h0101};
    line_read    = 1'b1;
    line_write   = 1'b1;
    tick();
    @(negedge clk);
    n_checks++; if ({burst_read, burst_write} !== 2'b10) begin
      n_fail++; $display("FAIL sim_read_first: got read/write %b exp 10", {burst_read, burst_write}); end
    burst_resp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      burst_rdata = 64'h00A0 + 64'(i);
      tick();
    end
    burst_resp = 1'b0;
    @(negedge clk);
    n_checks++; if (line_resp !== 1'b1) begin
      n_fail++; $display("FAIL sim_rd_resp: got %b exp 1", line_resp); end
    n_checks++; if (line_rdata !== {64'h00A3, 64'h00A2, 64'h00A1, 64'h00A0}) begin
      n_fail++; $display("FAIL sim_rd_line: got %h exp 00a3/00a2/00a1/00a0", line_rdata); end
    tick();
    line_read = 1'b0;
    @(negedge clk);
    n_checks++; if ({burst_read, burst_write, line_resp} !== 3'b000) begin
      n_fail++; $display("FAIL sim_idle_gap: got %b exp 000", {burst_read, burst_write, line_resp}); end
    tick();
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b1;
      @(negedge clk);
      n_checks++; if ({burst_write, burst_read} !== 2'b10 || burst_wdata !== wexp[i]) begin
        n_fail++; $display("FAIL sim_wr_beat%0d: got write/read %b data %h exp 10 %h",
                            i, {burst_write, burst_read}, burst_wdata, wexp[i]); end
      tick();
    end
    burst_resp = 1'b0;
    @(negedge clk);
    n_checks++; if (line_resp !== 1'b1) begin
      n_fail++; $display("FAIL sim_wr_resp: got %b exp 1", line_resp); end
    tick();
    line_write = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    line_address = 32'h0000_2000;
    line_read    = 1'b1;
    tick();
    burst_resp = 1'b1;
    burst_rdata = 64'h5555_5555_5555_5555; tick();
    burst_rdata = 64'h6666_6666_6666_6666; tick();
    burst_resp = 1'b0;
    line_read  = 1'b0;
    rst_n      = 1'b0;
    #1;
    n_checks++; if ({burst_read, burst_write, line_resp} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_ctrl: got %b exp 000", {burst_read, burst_write, line_resp}); end
    n_checks++; if (line_rdata !== 256'd0 || burst_address !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_regs: got rdata %h addr %h exp 0", line_rdata, burst_address); end
    @(negedge clk);
    n_checks++; if (line_resp !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_noresp: got %b exp 0", line_resp); end
    tick();
    rst_n = 1'b1;
    tick();
    drive_read(32'h0000_3000, 64'h77, 64'h88, 64'h99, 64'hAA);
    @(negedge clk);
    n_checks++; if (line_resp !== 1'b1 || line_rdata !== {64'hAA, 64'h99, 64'h88, 64'h77}) begin
      n_fail++; $display("FAIL rst_fresh_read: got resp %b line %h exp 1 aa/99/88/77", line_resp, line_rdata); end
    tick();
    line_read = 1'b0;
    tick();
  endtask

  task automatic test_stray_resp();
    burst_resp  = 1'b1;
    burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({line_resp, burst_read, burst_write} !== 3'b000) begin
        n_fail++; $display("FAIL stray_ctrl%0d: got %b exp 000", i, {line_resp, burst_read, burst_write}); end
      n_checks++; if (line_rdata !== {64'hAA, 64'h99, 64'h88, 64'h77}) begin
        n_fail++; $display("FAIL stray_rdata%0d: got %h exp aa/99/88/77", i, line_rdata); end
      tick();
    end
    burst_resp = 1'b0;
    tick();
    drive_read(32'h0000_0060, 64'h1, 64'h2, 64'h3, 64'h4);
    @(negedge clk);
    n_checks++; if (line_resp !== 1'b1 || line_rdata !== {64'h4, 64'h3, 64'h2, 64'h1}) begin
      n_fail++; $display("FAIL stray_then_read: got resp %b line %h exp 1 4/3/2/1", line_resp, line_rdata); end
    tick();
    line_read = 1'b0;
    tick();
  endtask

`ifdef ADAPTOR_WATCHDOG_EN
  task automatic test_watchdog();
    int n;
    line_address = 32'h0000_5000;
    line_read    = 1'b1;
    tick();
    n = 1;
    @(negedge clk);
    while (!line_resp && n < 100) begin
      tick();
      n++;
      @(negedge clk);
    end
    n_checks++; if (n !== 18) begin
      n_fail++; $display("FAIL wd_resp_cycle: got %0d exp 18", n); end
    n_checks++; if (wd_error !== 1'b1) begin
      n_fail++; $display("FAIL wd_error_set: got %b exp 1", wd_error); end
    tick();
    line_read = 1'b0;
    @(negedge clk);
    n_checks++; if (line_resp !== 1'b0) begin
      n_fail++; $display("FAIL wd_resp_single: got %b exp 0", line_resp); end
    repeat (5) tick();
    n_checks++; if (wd_error !== 1'b1) begin
      n_fail++; $display("FAIL wd_error_sticky: got %b exp 1", wd_error); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (wd_error !== 1'b0) begin
      n_fail++; $display("FAIL wd_error_reset: got %b exp 0", wd_error); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask
`else
  task automatic test_watchdog();
    line_address = 32'h0000_5000;
    line_read    = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_checks++; if ({burst_read, line_resp, wd_error} !== 3'b100) begin
        n_fail++; $display("FAIL nowd_stall%0d: got read/resp/err %b exp 100", i, {burst_read, line_resp, wd_error}); end
      tick();
    end
    burst_resp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      burst_rdata = 64'hC0 + 64'(i);
      tick();
    end
    burst_resp = 1'b0;
    @(negedge clk);
    n_checks++; if (line_resp !== 1'b1 || line_rdata !== {64'hC3, 64'hC2, 64'hC1, 64'hC0}) begin
      n_fail++; $display("FAIL nowd_complete: got resp %b line %h exp 1 c3/c2/c1/c0", line_resp, line_rdata); end
    tick();
    line_read = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_read_b2b();
    test_write_stall();
    test_simultaneous();
    test_reset_mid_burst();
    test_stray_resp();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Memory-side responder for the cache's pmem_* line interface.
- Accepts 256-bit line read/write requests from the cache.
- Serves each request as a 4-beat, 64-bit burst on the physical DRAM port.
- Sits between the cache (L1 or arbiter output) and the burst memory model/controller, and returns a one-cycle line response.

Parameters:
- BEATS, 4, beats per line; the line is always 256 bits (BEATS*64).
- WD_LIMIT, 1023, watchdog cycle limit; used only with ADAPTOR_WATCHDOG_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- line_address  in  32  line request address from cache (pmem_address)
- line_read  in  1  line read request; held until line_resp
- line_write  in  1  line write request; held until line_resp
- line_wdata  in  256  line to write (pmem_wdata)
- line_rdata  out  256  assembled read line (pmem_rdata)
- line_resp  out  1  one-cycle completion pulse (pmem_resp)
- burst_address  out  32  line-aligned burst address
- burst_read  out  1  burst read request
- burst_write  out  1  burst write request
- burst_wdata  out  64  current write beat
- burst_rdata  in  64  read beat, valid when burst_resp=1
- burst_resp  in  1  beat accepted/valid strobe
- wd_error  out  1  sticky watchdog error; 0 when feature is off

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, beat counter=0.
  - Address and data registers=0.
  - All outputs 0, including line_rdata.
- Reset asserted mid-burst aborts immediately: no line_resp; burst_read and burst_write drop asynchronously.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - line_read=1 → latch {line_address[31:5],5'b0}, go to RD.
  - Else line_write=1 → latch the address and line_wdata, go to WR.
  - Both high → read wins; the write is served after that read's DONE.
  - burst_resp in IDLE is ignored.
- RD:
  - burst_read=1 and burst_address=latched address throughout.
  - Each cycle with burst_resp=1 stores burst_rdata into line_rdata[64*cnt +: 64], then cnt++.
  - On the cycle the beat cnt==BEATS-1 is stored → DONE.
  - Beats may be non-consecutive; cycles with burst_resp=0 stall.
- WR:
  - burst_write=1; burst_wdata=latched_line[64*cnt +: 64] (combinational from cnt).
  - burst_resp=1 advances cnt.
  - Last beat accepted → DONE.
- DONE:
  - line_resp=1 for exactly one cycle; burst_read and burst_write are 0.
  - Next state is IDLE, cnt=0.
  - line_rdata stays stable from DONE until the next read's first beat.
- Handshake and latency:
  - Upstream deasserts its request in the cycle after line_resp.
  - Request still high in IDLE after DONE → treated as a new request.
  - Minimum latency: request sampled at edge 0 → burst_read high in cycle 1 → beats in cycles 1-4 → line_resp in cycle 5.
- Request changes mid-burst are ignored; the latched address and data are used.
- The counter is log2(BEATS) bits wide and wraps to 0 on entry to DONE.

Optional Feature:
- ADAPTOR_WATCHDOG_EN defined:
  - A cycle counter clears on every burst_resp and on entry to RD/WR, and increments while in RD/WR.
  - Reaching WD_LIMIT sets wd_error (sticky until reset) and forces DONE.
  - The forced DONE still pulses line_resp, with partially assembled line_rdata.
- Undefined: no counter logic; wd_error tied 0; bursts wait indefinitely.

Test Plan:
- Read, back-to-back beats:
  - Stimulus: line_read at 0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with burst_resp high 4 consecutive cycles.
  - Required: burst_address=0x0000_1220; line_rdata={0x44..44,0x33..33,0x22..22,0x11..11}; line_resp exactly 1 cycle, in cycle 5.
- Write, stalled beats:
  - Stimulus: line_write with line_wdata[63:0]=0xA, [127:64]=0xB, [191:128]=0xC, [255:192]=0xD; burst_resp every other cycle.
  - Required: burst_wdata sequence A,B,C,D, each held until accepted; one line_resp after the 4th accept.
- Simultaneous requests:
  - Stimulus: line_read and line_write both high in IDLE.
  - Required: burst_read is issued first; after that line_resp, the still-held write produces a burst_write.
- Reset mid-burst:
  - Stimulus: rst_n=0 after 2 read beats, then release, then a fresh read.
  - Required: outputs 0 immediately with no line_resp; the fresh read completes normally starting at beat 0.
- Stray burst_resp:
  - Stimulus: burst_resp pulsed while in IDLE.
  - Required: no state change, no line_resp, line_rdata unchanged.
- Watchdog (ADAPTOR_WATCHDOG_EN, WD_LIMIT=16):
  - Stimulus: read with no burst_resp.
  - Required: wd_error=1 and a single line_resp about 17 cycles after entering RD; wd_error stays 1 until rst_n is asserted.
